// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, read-owner encoding, mask width.
package dmem_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } arb_owner_e;

    localparam int MASK_W = 4;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating 8-bit count of consecutive cycles master 1 was denied; sat_o flags MAX_WAIT.
module arb_wait_counter #(
    parameter int MAX_WAIT = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       inc_i,
    input  logic       clr_i,
    output logic [7:0] cnt_o,
    output logic       sat_o
);

    localparam logic [7:0] MAX_C = 8'(MAX_WAIT);

    logic [7:0] cnt_r;

    // Counter register: clear wins over increment, and the count holds once saturated.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_r <= 8'd0;
        end else if (clr_i) begin
            cnt_r <= 8'd0;
        end else if (inc_i && (cnt_r != MAX_C)) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Saturation flag taken straight from the register.
    always_comb begin
        cnt_o = cnt_r;
        sat_o = (cnt_r == MAX_C);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the data-memory port: core (m0) has priority, m1 is starvation-bounded.
// Optional locked bursts for m1 are compiled in with `define DMEM_ARB_LOCK_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [AW-1:0]     m0_addr_i,
    input  logic [DW-1:0]     m0_wdata_i,
    input  logic [MASK_W-1:0] m0_mask_i,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [AW-1:0]     m1_addr_i,
    input  logic [DW-1:0]     m1_wdata_i,
    input  logic [MASK_W-1:0] m1_mask_i,
    input  logic              m1_lock_i,
    output logic              m0_gnt_o,
    output logic              m1_gnt_o,
    output logic              m0_rvalid_o,
    output logic              m1_rvalid_o,
    output logic [DW-1:0]     m0_rdata_o,
    output logic [DW-1:0]     m1_rdata_o,
    output logic              core_stall_o,
    output logic              mem_we_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [DW-1:0]     mem_wdata_o,
    output logic [MASK_W-1:0] mem_mask_o,
    input  logic [DW-1:0]     mem_rdata_i
);

    arb_state_e state_r;
    logic       rd_pend_r;
    arb_owner_e rd_owner_r;
    logic       gnt0_s;
    logic       gnt1_s;
    logic       wait_sat_s;
    logic [7:0] wait_cnt_s;
    logic       locked_s;
    logic       rd_ret0_s;
    logic       rd_ret1_s;

`ifdef DMEM_ARB_LOCK_EN
    assign locked_s = (state_r == LOCK);
`else
    logic unused_lock_s;
    assign unused_lock_s = m1_lock_i;
    assign locked_s      = 1'b0;
`endif

    // Grant decision: same-cycle, nothing while in reset, m1 owns the port while locked.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!rst_i) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (locked_s) begin
            gnt1_s = m1_req_i;
        end else begin
            case ({m1_req_i, m0_req_i})
                2'b01:   gnt0_s = 1'b1;
                2'b10:   gnt1_s = 1'b1;
                2'b11: begin
                    gnt1_s = wait_sat_s;
                    gnt0_s = ~wait_sat_s;
                end
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end
    end

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (m1_req_i & ~gnt1_s),
        .clr_i (~m1_req_i | gnt1_s),
        .cnt_o (wait_cnt_s),
        .sat_o (wait_sat_s)
    );

    // Arbiter FSM plus read-return bookkeeping.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r    <= ARB;
            rd_pend_r  <= 1'b0;
            rd_owner_r <= OWN_M0;
        end else begin
            rd_pend_r  <= (gnt0_s & ~m0_we_i) | (gnt1_s & ~m1_we_i);
            rd_owner_r <= gnt1_s ? OWN_M1 : OWN_M0;
`ifdef DMEM_ARB_LOCK_EN
            case (state_r)
                ARB:     state_r <= (gnt1_s && m1_lock_i) ? LOCK : ARB;
                LOCK:    state_r <= (!m1_req_i || !m1_lock_i) ? ARB : LOCK;
                default: state_r <= ARB;
            endcase
`else
            state_r <= ARB;
`endif
        end
    end

    // Memory port mux; an idle port still presents m0's address and data.
    always_comb begin
        mem_addr_o  = m0_addr_i;
        mem_wdata_o = m0_wdata_i;
        mem_we_o    = 1'b0;
        mem_mask_o  = {MASK_W{1'b0}};
        case ({gnt1_s, gnt0_s})
            2'b01: begin
                mem_we_o   = m0_we_i;
                mem_mask_o = m0_mask_i;
            end
            2'b10: begin
                mem_addr_o  = m1_addr_i;
                mem_wdata_o = m1_wdata_i;
                mem_we_o    = m1_we_i;
                mem_mask_o  = m1_mask_i;
            end
            default: begin
                mem_we_o   = 1'b0;
                mem_mask_o = {MASK_W{1'b0}};
            end
        endcase
    end

    // Read return: a pending read is dropped if reset is asserted in its return cycle.
    always_comb begin
        rd_ret0_s    = rst_i & rd_pend_r & (rd_owner_r == OWN_M0);
        rd_ret1_s    = rst_i & rd_pend_r & (rd_owner_r == OWN_M1);
        m0_gnt_o     = gnt0_s;
        m1_gnt_o     = gnt1_s;
        core_stall_o = m0_req_i & ~gnt0_s;
        m0_rvalid_o  = rd_ret0_s;
        m1_rvalid_o  = rd_ret1_s;
        m0_rdata_o   = rd_ret0_s ? mem_rdata_i : {DW{1'b0}};
        m1_rdata_o   = rd_ret1_s ? mem_rdata_i : {DW{1'b0}};
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed table, hand sequences and a randomized run against a rule-level model.
module tb_dmem_arbiter;

    localparam int MW = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_mask, m1_mask;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, core_stall, mem_we;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_mask;

    int n_cmp = 0;
    int n_err = 0;

    dmem_arbiter #(.DW(32), .AW(32), .MAX_WAIT(MW)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_mask_i(m0_mask),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_mask_i(m1_mask),
        .m1_lock_i(m1_lock),
        .m0_gnt_o(m0_gnt), .m1_gnt_o(m1_gnt), .m0_rvalid_o(m0_rvalid), .m1_rvalid_o(m1_rvalid),
        .m0_rdata_o(m0_rdata), .m1_rdata_o(m1_rdata), .core_stall_o(core_stall),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_mask_o(mem_mask),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Data memory behind the arbiter: byte-masked write, synchronous read.
    logic [31:0] mem [0:15];
    always @(posedge clk) begin
        if (mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_mask[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        mem_rdata <= mem[mem_addr[5:2]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] k);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (k[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Reference model: denied-cycle count, pending read, lock flag, shadow memory.
    int          mw_cnt = 0;
    bit          pend = 0, pend_own = 0, pend_ok = 0, locked = 0;
    logic [31:0] pend_dat = 32'h0;
    logic [31:0] shadow [0:15];
    bit          svalid [0:15];
    bit          e0, e1;

    initial for (int i = 0; i < 16; i++) svalid[i] = 1'b0;

    task automatic model_check();
        logic [31:0] ea, ed;
        logic [3:0]  ek;
        logic        ew, v0, v1;
        e0 = 1'b0; e1 = 1'b0;
        if (rst) begin
            if (locked)                e1 = m1_req;
            else if (m0_req && m1_req) begin e1 = (mw_cnt >= MW); e0 = !e1; end
            else begin e0 = m0_req; e1 = m1_req; end
        end
        ea = e1 ? m1_addr : m0_addr;
        ed = e1 ? m1_wdata : m0_wdata;
        ew = e1 ? m1_we : (e0 ? m0_we : 1'b0);
        ek = e1 ? m1_mask : (e0 ? m0_mask : 4'h0);
        v0 = rst && pend && !pend_own;
        v1 = rst && pend && pend_own;
        chk("m0_gnt", m0_gnt, e0);
        chk("m1_gnt", m1_gnt, e1);
        chk("core_stall", core_stall, m0_req & ~e0);
        chk("mem_we", mem_we, ew);
        chk("mem_mask", mem_mask, ek);
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ed);
        chk("m0_rvalid", m0_rvalid, v0);
        chk("m1_rvalid", m1_rvalid, v1);
        if (!v0 || pend_ok) chk("m0_rdata", m0_rdata, v0 ? pend_dat : 32'h0);
        if (!v1 || pend_ok) chk("m1_rdata", m1_rdata, v1 ? pend_dat : 32'h0);
    endtask

    task automatic model_update();
        logic [31:0] a, d;
        logic [3:0]  k;
        logic        w;
        if (!rst) begin
            mw_cnt = 0; pend = 0; locked = 0;
        end else begin
            a = e1 ? m1_addr : m0_addr;
            d = e1 ? m1_wdata : m0_wdata;
            k = e1 ? m1_mask : m0_mask;
            w = e1 ? m1_we : m0_we;
            pend = 0;
            if (e0 || e1) begin
                if (!w) begin
                    pend = 1; pend_own = e1; pend_dat = shadow[a[5:2]]; pend_ok = svalid[a[5:2]];
                end else begin
                    shadow[a[5:2]] = merge(shadow[a[5:2]], d, k);
                    if (k == 4'hF) svalid[a[5:2]] = 1'b1;
                end
            end
            if (m1_req && !e1) mw_cnt = (mw_cnt < MW) ? mw_cnt + 1 : mw_cnt;
            else               mw_cnt = 0;
`ifdef DMEM_ARB_LOCK_EN
            if (locked) locked = m1_req && m1_lock;
            else        locked = e1 && m1_lock;
`endif
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        model_check();
    endtask

    task automatic adv();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 0; m0_we = 0; m1_req = 0; m1_we = 0; m1_lock = 0;
    endtask

    typedef struct {
        bit rst, r0, w0, r1, w1;
        bit g0, g1, st, mwe;
    } vec_t;
    vec_t tbl [0:23];

    initial begin
        rst = 0; idle();
        m0_addr = 32'h0; m1_addr = 32'h4; m0_wdata = 32'h1111_0000; m1_wdata = 32'h2222_0000;
        m0_mask = 4'hF; m1_mask = 4'hF;

        //          rst r0 w0 r1 w1  g0 g1 st mwe
        tbl[0]  = '{0, 1, 0, 1, 0,  0, 0, 1, 0};
        tbl[1]  = '{0, 1, 0, 1, 0,  0, 0, 1, 0};
        tbl[2]  = '{1, 1, 0, 1, 0,  1, 0, 0, 0};
        tbl[3]  = '{1, 1, 0, 1, 0,  1, 0, 0, 0};
        tbl[4]  = '{1, 1, 0, 1, 0,  1, 0, 0, 0};
        tbl[5]  = '{1, 1, 0, 1, 0,  0, 1, 1, 0};
        tbl[6]  = '{1, 1, 0, 1, 0,  1, 0, 0, 0};
        tbl[7]  = '{1, 1, 0, 1, 0,  1, 0, 0, 0};
        tbl[8]  = '{1, 1, 0, 1, 0,  1, 0, 0, 0};
        tbl[9]  = '{1, 1, 0, 1, 0,  0, 1, 1, 0};
        tbl[10] = '{1, 0, 0, 1, 1,  0, 1, 0, 1};
        tbl[11] = '{1, 0, 0, 0, 0,  0, 0, 0, 0};
        tbl[12] = '{1, 1, 1, 0, 0,  1, 0, 0, 1};
        tbl[13] = '{1, 0, 0, 1, 0,  0, 1, 0, 0};
        tbl[14] = '{1, 1, 0, 1, 0,  1, 0, 0, 0};
        tbl[15] = '{1, 1, 0, 0, 0,  1, 0, 0, 0};
        tbl[16] = '{1, 1, 0, 1, 0,  1, 0, 0, 0};
        tbl[17] = '{1, 1, 0, 1, 0,  1, 0, 0, 0};
        tbl[18] = '{1, 1, 0, 1, 0,  1, 0, 0, 0};
        tbl[19] = '{1, 1, 0, 0, 0,  1, 0, 0, 0};
        tbl[20] = '{1, 1, 0, 1, 0,  1, 0, 0, 0};
        tbl[21] = '{1, 1, 0, 1, 0,  1, 0, 0, 0};
        tbl[22] = '{1, 1, 0, 1, 0,  1, 0, 0, 0};
        tbl[23] = '{1, 1, 0, 1, 0,  0, 1, 1, 0};

        for (int i = 0; i < 24; i++) begin
            bit p0, p1;
            p0 = (i > 0) && tbl[i-1].g0 && !tbl[i-1].w0;
            p1 = (i > 0) && tbl[i-1].g1 && !tbl[i-1].w1;
            rst = tbl[i].rst; m0_req = tbl[i].r0; m0_we = tbl[i].w0; m1_req = tbl[i].r1; m1_we = tbl[i].w1;
            cyc();
            chk($sformatf("tbl%0d_g0", i), m0_gnt, tbl[i].g0);
            chk($sformatf("tbl%0d_g1", i), m1_gnt, tbl[i].g1);
            chk($sformatf("tbl%0d_stall", i), core_stall, tbl[i].st);
            chk($sformatf("tbl%0d_we", i), mem_we, tbl[i].mwe);
            chk($sformatf("tbl%0d_rv0", i), m0_rvalid, p0 & tbl[i].rst);
            chk($sformatf("tbl%0d_rv1", i), m1_rvalid, p1 & tbl[i].rst);
            adv();
        end

        // Solo read of 0xDEADBEEF at 0x10, preloaded through m0.
        idle();
        cyc(); adv();
        m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEAD_BEEF; m0_mask = 4'hF;
        cyc(); adv();
        m0_we = 0;
        cyc(); chk("solo_gnt", m0_gnt, 1'b1); adv();
        m0_req = 0;
        cyc();
        chk("solo_rvalid", m0_rvalid, 1'b1);
        chk("solo_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("solo_m1_rvalid", m1_rvalid, 1'b0);
        chk("solo_m1_rdata", m1_rdata, 32'h0);
        adv();

        // m1 write routing with m0 idle.
        m1_req = 1; m1_we = 1; m1_addr = 32'h24; m1_wdata = 32'hA5A5_A5A5; m1_mask = 4'b0011;
        cyc();
        chk("wr_we", mem_we, 1'b1);
        chk("wr_mask", mem_mask, 4'b0011);
        chk("wr_wdata", mem_wdata, 32'hA5A5_A5A5);
        chk("wr_addr", mem_addr, 32'h24);
        adv();
        idle();
        cyc();
        chk("wr_rv0", m0_rvalid, 1'b0);
        chk("wr_rv1", m1_rvalid, 1'b0);
        adv();

        // Reset in the cycle after a granted read, with m1 having been denied.
        m0_req = 1; m0_we = 0; m1_req = 1; m1_we = 0;
        cyc(); chk("rst_rd_gnt", m0_gnt, 1'b1); adv();
        rst = 0;
        cyc(); chk("rst_rd_rv0", m0_rvalid, 1'b0); chk("rst_rd_g0", m0_gnt, 1'b0); adv();
        rst = 1; idle();
        cyc(); chk("rst_rd_rv0_after", m0_rvalid, 1'b0); chk("rst_wait_cnt", dut.wait_cnt_s, 32'd0); adv();

`ifdef DMEM_ARB_LOCK_EN
        // Locked burst: m1 wins by starvation, holds the port for 4 locked grants, then releases.
        m0_req = 1; m1_req = 1; m1_lock = 1; m0_we = 0; m1_we = 0;
        for (int i = 0; i < MW; i++) begin cyc(); chk("lk_pre_g0", m0_gnt, 1'b1); adv(); end
        for (int i = 0; i < 4; i++) begin
            cyc(); chk("lk_g1", m1_gnt, 1'b1); chk("lk_g0", m0_gnt, 1'b0); chk("lk_stall", core_stall, 1'b1); adv();
        end
        m1_lock = 0;
        cyc(); chk("lk_last_g1", m1_gnt, 1'b1); chk("lk_last_g0", m0_gnt, 1'b0); adv();
        m1_req = 0;
        cyc(); chk("lk_after_g0", m0_gnt, 1'b1); adv();
`endif

        // Fill every memory word so random reads have known data.
        idle();
        for (int i = 0; i < 16; i++) begin
            m0_req = 1; m0_we = 1; m0_mask = 4'hF; m0_addr = 32'(i * 4); m0_wdata = $urandom;
            cyc(); adv();
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            rst      = ($urandom_range(0, 49) != 0);
            m0_req   = ($urandom_range(0, 9) < 7);
            m1_req   = ($urandom_range(0, 9) < 6);
            m0_we    = $urandom_range(0, 1);
            m1_we    = $urandom_range(0, 1);
            m1_lock  = ($urandom_range(0, 3) == 0);
            m0_addr  = $urandom; m1_addr = $urandom;
            m0_wdata = $urandom; m1_wdata = $urandom;
            m0_mask  = 4'($urandom); m1_mask = 4'($urandom);
            cyc(); adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
